// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 4-bit CPU control path: instruction opcode and
// system sub-op encodings, ALU operation codes, sequencer state encoding and
// small instruction-field helpers.
//
// Instruction format: instr[7:6] opcode, [5:4] rd / sub-op, [3:2] ra, [1:0] rb,
// [3:0] imm4 / branch target.
// -----------------------------------------------------------------------------
package cpu_pkg;

   // Major opcodes, instr[7:6]
   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_NAND = 2'b10;
   localparam logic [1:0] OP_SYS  = 2'b11;

   // System sub-ops, instr[5:4] when opcode is OP_SYS
   localparam logic [1:0] SYS_NOP  = 2'b00;
   localparam logic [1:0] SYS_HALT = 2'b01;
   localparam logic [1:0] SYS_BRZ  = 2'b10;
   localparam logic [1:0] SYS_RSVD = 2'b11;

   // ALU operation select
   localparam logic ALU_ADD  = 1'b0;
   localparam logic ALU_NAND = 1'b1;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_FETCH  = 2'b01,
      ST_EXEC   = 2'b10,
      ST_HALTED = 2'b11
   } state_e;

   // Field extraction helpers
   function automatic logic [1:0] instr_op(input logic [7:0] instr);
      return instr[7:6];
   endfunction

   function automatic logic [1:0] instr_rd(input logic [7:0] instr);
      return instr[5:4];
   endfunction

   function automatic logic [1:0] instr_ra(input logic [7:0] instr);
      return instr[3:2];
   endfunction

   function automatic logic [1:0] instr_rb(input logic [7:0] instr);
      return instr[1:0];
   endfunction

   function automatic logic [3:0] instr_imm(input logic [7:0] instr);
      return instr[3:0];
   endfunction

endpackage

// File: rtl/cpu_decode.sv
// -----------------------------------------------------------------------------
// cpu_decode
// Purely combinational instruction decoder. While exec_i is high it maps the
// 8-bit instruction onto the datapath controls; while exec_i is low every
// output is forced to 0 so the datapath sees quiet controls outside EXEC.
//
// Ports:
//   instr_i     in  8  instruction word from the program ROM
//   exec_i      in  1  sequencer is in EXEC
//   sel_a_o     out 2  ALU operand A register select
//   sel_b_o     out 2  ALU operand B register select
//   sel_w_o     out 2  write-back register select
//   imm_o       out 4  immediate value (PUSH only)
//   sel_data_o  out 1  1 = write immediate, 0 = write ALU result
//   write_en_o  out 1  register-file write strobe (PUSH/ADD/NAND)
//   alu_op_o    out 1  0 = add, 1 = nand
//   is_halt_o   out 1  HALT decoded
//   is_brz_o    out 1  BRZ decoded
// -----------------------------------------------------------------------------
module cpu_decode
   import cpu_pkg::*;
(
   input  logic [7:0] instr_i,
   input  logic       exec_i,
   output logic [1:0] sel_a_o,
   output logic [1:0] sel_b_o,
   output logic [1:0] sel_w_o,
   output logic [3:0] imm_o,
   output logic       sel_data_o,
   output logic       write_en_o,
   output logic       alu_op_o,
   output logic       is_halt_o,
   output logic       is_brz_o
);

   // Instruction decode; all controls default to 0 and only EXEC enables them
   always_comb begin
      sel_a_o    = 2'b00;
      sel_b_o    = 2'b00;
      sel_w_o    = 2'b00;
      imm_o      = 4'h0;
      sel_data_o = 1'b0;
      write_en_o = 1'b0;
      alu_op_o   = ALU_ADD;
      is_halt_o  = 1'b0;
      is_brz_o   = 1'b0;
      if (exec_i) begin
         case (instr_op(instr_i))
            OP_PUSH: begin
               sel_w_o    = instr_rd(instr_i);
               imm_o      = instr_imm(instr_i);
               sel_data_o = 1'b1;
               write_en_o = 1'b1;
            end
            OP_ADD: begin
               sel_a_o    = instr_ra(instr_i);
               sel_b_o    = instr_rb(instr_i);
               sel_w_o    = instr_rd(instr_i);
               alu_op_o   = ALU_ADD;
               write_en_o = 1'b1;
            end
            OP_NAND: begin
               sel_a_o    = instr_ra(instr_i);
               sel_b_o    = instr_rb(instr_i);
               sel_w_o    = instr_rd(instr_i);
               alu_op_o   = ALU_NAND;
               write_en_o = 1'b1;
            end
            OP_SYS: begin
               // NOP and the reserved sub-op produce no controls at all
               case (instr_rd(instr_i))
                  SYS_HALT: is_halt_o = 1'b1;
                  SYS_BRZ:  is_brz_o  = 1'b1;
                  SYS_NOP:  is_halt_o = 1'b0;
                  SYS_RSVD: is_halt_o = 1'b0;
                  default:  is_halt_o = 1'b0;
               endcase
            end
            default: begin
               write_en_o = 1'b0;
            end
         endcase
      end else begin
         write_en_o = 1'b0;
      end
   end

endmodule

// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control
// Fetch/execute sequencer for the 4-bit register-file CPU. Holds the program
// counter, addresses the synchronous program ROM, and drives the datapath
// controls through cpu_decode. Each instruction takes two cycles: FETCH
// presents pc to the ROM, EXEC decodes the returned word and advances pc.
//
// Optional feature: define CTRL_BRANCH_EN to enable BRZ (11 10 tttt), which
// loads pc with tttt when r0_val is zero. Without it BRZ executes as NOP and
// r0_val is ignored.
//
// Ports:
//   clk       in  1     system clock, rising edge
//   rst       in  1     synchronous active-high reset
//   start     in  1     start pulse, honoured in IDLE and HALTED only
//   instr     in  8     ROM data, valid the cycle after pc is presented
//   r0_val    in  4     current R0 value (BRZ condition)
//   pc        out PC_W  ROM address
//   SEL_A     out 2     ALU operand A register select
//   SEL_B     out 2     ALU operand B register select
//   SEL_W     out 2     write-back register select
//   IMM       out 4     immediate value
//   sel_data  out 1     1 = write IMM, 0 = write ALU result
//   write_en  out 1     register-file write strobe
//   alu_op    out 1     0 = add, 1 = nand
//   busy      out 1     high in FETCH and EXEC
//   halted    out 1     high in HALTED
// -----------------------------------------------------------------------------
module cpu_control
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W     = 4,
   parameter int unsigned RESET_PC = 0
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [7:0]      instr,
   input  logic [3:0]      r0_val,
   output logic [PC_W-1:0] pc,
   output logic [1:0]      SEL_A,
   output logic [1:0]      SEL_B,
   output logic [1:0]      SEL_W,
   output logic [3:0]      IMM,
   output logic            sel_data,
   output logic            write_en,
   output logic            alu_op,
   output logic            busy,
   output logic            halted
);

   localparam logic [PC_W-1:0] RESET_PC_C = PC_W'(RESET_PC);

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] pc_inc_s;
   logic            busy_q;
   logic            halted_q;
   logic            exec_s;
   logic            is_halt_s;
   logic            is_brz_s;
   logic            brz_taken_s;
   logic [PC_W-1:0] brz_target_s;

   // Controls are only live in EXEC; the write strobe is combinational so a
   // reset arriving during EXEC still lets that cycle's write land.
   assign exec_s = (state_q == ST_EXEC);

   cpu_decode u_decode (
      .instr_i    (instr),
      .exec_i     (exec_s),
      .sel_a_o    (SEL_A),
      .sel_b_o    (SEL_B),
      .sel_w_o    (SEL_W),
      .imm_o      (IMM),
      .sel_data_o (sel_data),
      .write_en_o (write_en),
      .alu_op_o   (alu_op),
      .is_halt_o  (is_halt_s),
      .is_brz_o   (is_brz_s)
   );

   // Sequential increment wraps naturally from 2^PC_W-1 to 0
   assign pc_inc_s = pc_q + PC_W'(1);

`ifdef CTRL_BRANCH_EN
   // r0_val already reflects the previous instruction's write at this point
   assign brz_taken_s  = is_brz_s && (r0_val == 4'h0);
   assign brz_target_s = PC_W'(instr[3:0]);
`else
   // BRZ falls through like a NOP; branch inputs are intentionally unused
   logic unused_branch_s;
   assign unused_branch_s = ^{r0_val, is_brz_s};
   assign brz_taken_s     = 1'b0;
   assign brz_target_s    = pc_inc_s;
`endif

   assign pc_d = brz_taken_s ? brz_target_s : pc_inc_s;

   // Sequencer FSM with program counter and registered status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC_C;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  state_q  <= ST_FETCH;
                  pc_q     <= RESET_PC_C;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
               end else begin
                  state_q  <= state_q;
                  pc_q     <= pc_q;
                  busy_q   <= 1'b0;
                  halted_q <= (state_q == ST_HALTED);
               end
            end
            ST_FETCH: begin
               // ROM word for pc_q arrives next cycle; start is ignored here
               state_q  <= ST_EXEC;
               busy_q   <= 1'b1;
               halted_q <= 1'b0;
            end
            ST_EXEC: begin
               if (is_halt_s) begin
                  // pc stays on the HALT instruction
                  state_q  <= ST_HALTED;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  state_q  <= ST_FETCH;
                  pc_q     <= pc_d;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               pc_q     <= RESET_PC_C;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc     = pc_q;
   assign busy   = busy_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_cpu_control.sv
// -----------------------------------------------------------------------------
// tb_cpu_control
// Self-checking bench for cpu_control with a synchronous ROM model, a small
// register-file datapath model and an expected-write scoreboard.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_control;

   localparam int PC_W = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [7:0]      instr;
   logic [3:0]      r0_val;
   logic [PC_W-1:0] pc;
   logic [1:0]      SEL_A, SEL_B, SEL_W;
   logic [3:0]      IMM;
   logic            sel_data, write_en, alu_op, busy, halted;

   logic [7:0]  rom [16];
   logic [3:0]  rf  [4];
   logic [11:0] exp_q [$];
   logic [11:0] obs;
   int          n_cmp  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   cpu_control #(.PC_W(PC_W), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .start(start), .instr(instr), .r0_val(r0_val),
      .pc(pc), .SEL_A(SEL_A), .SEL_B(SEL_B), .SEL_W(SEL_W), .IMM(IMM),
      .sel_data(sel_data), .write_en(write_en), .alu_op(alu_op),
      .busy(busy), .halted(halted)
   );

   // Synchronous program ROM
   always @(posedge clk) instr <= rom[pc];

   // Register-file datapath: IMM or ALU result captured on the edge ending EXEC
   always @(posedge clk) begin
      if (write_en)
         rf[SEL_W] <= sel_data ? IMM :
                      (alu_op ? ~(rf[SEL_A] & rf[SEL_B]) : 4'(rf[SEL_A] + rf[SEL_B]));
   end

   assign r0_val = rf[0];
   assign obs    = {SEL_A, SEL_B, SEL_W, IMM, sel_data, alu_op};

   // Expected control word {SEL_A, SEL_B, SEL_W, IMM, sel_data, alu_op}
   function automatic logic [11:0] wr(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] w, input logic [3:0] imm,
                                      input logic sd, input logic op);
      return {a, b, w, imm, sd, op};
   endfunction

   task automatic fill_rom(input logic [7:0] v);
      for (int i = 0; i < 16; i++) rom[i] = v;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc); end
      n_cmp++; if ({write_en, busy, halted} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {write_en, busy, halted}); end
      n_cmp++; if (obs !== 12'h000) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 000", obs); end
   endtask

   task automatic test_push();
      int cyc; int last;
      logic [11:0] e;
      fill_rom(8'hD0);
      rom[0] = 8'h00; rom[1] = 8'h1F; rom[2] = 8'h22; rom[3] = 8'h3D; rom[4] = 8'hD0;
      exp_q.push_back(wr(2'd0, 2'd0, 2'd0, 4'h0, 1'b1, 1'b0));
      exp_q.push_back(wr(2'd0, 2'd0, 2'd1, 4'hF, 1'b1, 1'b0));
      exp_q.push_back(wr(2'd0, 2'd0, 2'd2, 4'h2, 1'b1, 1'b0));
      exp_q.push_back(wr(2'd0, 2'd0, 2'd3, 4'hD, 1'b1, 1'b0));
      pulse_start();
      cyc = 1; last = -1;
      while (!halted && cyc < 40) begin
         @(negedge clk); cyc++;
         if (write_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL push_sb: unexpected write %h", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin n_fail++; $display("FAIL push_sb: got %h expected %h", obs, e); end
            end
            n_cmp++;
            if (last < 0 && cyc != 2) begin n_fail++; $display("FAIL push_latency: got %0d expected 2", cyc); end
            else if (last >= 0 && cyc - last != 2) begin n_fail++; $display("FAIL push_spacing: got %0d expected 2", cyc - last); end
            last = cyc;
         end
      end
      n_cmp++; if (!halted) begin n_fail++; $display("FAIL push_timeout: halted %b expected 1", halted); end
      n_cmp++; if (pc !== 4'd4) begin n_fail++; $display("FAIL push_pc: got %0d expected 4", pc); end
      n_cmp++; if ({rf[0], rf[1], rf[2], rf[3]} !== 16'h0F2D) begin n_fail++; $display("FAIL push_regs: got %h expected 0f2d", {rf[0], rf[1], rf[2], rf[3]}); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL push_left: got %0d expected 0", exp_q.size()); end
   endtask

   task automatic test_alu();
      int cyc;
      logic [11:0] e;
      fill_rom(8'hD0);
      rom[0] = 8'h46; rom[1] = 8'h9B; rom[2] = 8'h6A; rom[3] = 8'hD0;
      exp_q.push_back(wr(2'd1, 2'd2, 2'd0, 4'h0, 1'b0, 1'b0));
      exp_q.push_back(wr(2'd2, 2'd3, 2'd1, 4'h0, 1'b0, 1'b1));
      exp_q.push_back(wr(2'd2, 2'd2, 2'd2, 4'h0, 1'b0, 1'b0));
      pulse_start();
      cyc = 1;
      while (!halted && cyc < 40) begin
         @(negedge clk); cyc++;
         if (write_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL alu_sb: unexpected write %h", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin n_fail++; $display("FAIL alu_sb: got %h expected %h", obs, e); end
            end
         end
      end
      n_cmp++; if (!halted || pc !== 4'd3) begin n_fail++; $display("FAIL alu_halt: got halted=%b pc=%0d expected 1/3", halted, pc); end
      n_cmp++; if ({rf[0], rf[1], rf[2], rf[3]} !== 16'h1F4D) begin n_fail++; $display("FAIL alu_regs: got %h expected 1f4d", {rf[0], rf[1], rf[2], rf[3]}); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL alu_left: got %0d expected 0", exp_q.size()); end
   endtask

   task automatic test_nop_wrap();
      int wr_seen; int busy_low;
      fill_rom(8'hD0);
      rom[0] = 8'hC0; rom[1] = 8'hF0;
      pulse_start();
      wr_seen = 0;
      n_cmp++; if (pc !== 4'd0) begin n_fail++; $display("FAIL nop_pc0: got %0d expected 0", pc); end
      repeat (4) begin @(negedge clk); if (write_en) wr_seen++; end
      n_cmp++; if (pc !== 4'd2) begin n_fail++; $display("FAIL nop_pc2: got %0d expected 2", pc); end
      n_cmp++; if (wr_seen != 0) begin n_fail++; $display("FAIL nop_writes: got %0d expected 0", wr_seen); end
      repeat (2) @(negedge clk);
      n_cmp++; if (!halted || pc !== 4'd2) begin n_fail++; $display("FAIL nop_halt: got halted=%b pc=%0d expected 1/2", halted, pc); end
      // 16 NOPs: pc must wrap F -> 0 while staying busy
      fill_rom(8'hC0);
      pulse_start();
      busy_low = 0; wr_seen = 0;
      for (int k = 1; k <= 16; k++) begin
         repeat (2) begin @(negedge clk); if (!busy) busy_low++; if (write_en) wr_seen++; end
         if (k == 15) begin
            n_cmp++; if (pc !== 4'hF) begin n_fail++; $display("FAIL wrap_pcF: got %0d expected 15", pc); end
         end
      end
      n_cmp++; if (pc !== 4'h0) begin n_fail++; $display("FAIL wrap_pc0: got %0d expected 0", pc); end
      n_cmp++; if (busy_low != 0 || wr_seen != 0) begin n_fail++; $display("FAIL wrap_busy: got busy_low=%0d writes=%0d expected 0/0", busy_low, wr_seen); end
      rst = 1'b1; @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [11:0] e;
      fill_rom(8'hD0);
      rom[0] = 8'h00; rom[1] = 8'h1F; rom[2] = 8'h22; rom[3] = 8'h3D; rom[4] = 8'hD0;
      exp_q.push_back(wr(2'd0, 2'd0, 2'd0, 4'h0, 1'b1, 1'b0));
      exp_q.push_back(wr(2'd0, 2'd0, 2'd1, 4'hF, 1'b1, 1'b0));
      pulse_start();
      repeat (4) begin
         @(negedge clk);
         if (write_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_sb: unexpected write %h", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin n_fail++; $display("FAIL rstmid_sb: got %h expected %h", obs, e); end
            end
         end
      end
      // now in FETCH of the third instruction
      n_cmp++; if (pc !== 4'd2 || !busy) begin n_fail++; $display("FAIL rstmid_fetch: got pc=%0d busy=%b expected 2/1", pc, busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (pc !== 4'd0) begin n_fail++; $display("FAIL rstmid_pc: got %0d expected 0", pc); end
      n_cmp++; if ({write_en, busy, halted} !== 3'b000 || obs !== 12'h000) begin n_fail++; $display("FAIL rstmid_out: got %b/%h expected 000/000", {write_en, busy, halted}, obs); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%b left=%0d expected 0/0", busy, exp_q.size()); end
   endtask

   task automatic test_start_busy();
      int cyc;
      fill_rom(8'hD0);
      rom[0] = 8'h00; rom[1] = 8'h1F; rom[2] = 8'h22; rom[3] = 8'h3D; rom[4] = 8'hD0;
      pulse_start();
      @(negedge clk); start = 1'b1;   // EXEC of pc 0
      @(negedge clk); start = 1'b0;   // FETCH of pc 1
      n_cmp++; if (pc !== 4'd1 || !busy) begin n_fail++; $display("FAIL busy_start1: got pc=%0d busy=%b expected 1/1", pc, busy); end
      start = 1'b1;                   // pulse during FETCH as well
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      n_cmp++; if (pc !== 4'd2) begin n_fail++; $display("FAIL busy_start2: got %0d expected 2", pc); end
      cyc = 0;
      while (!halted && cyc < 20) begin @(negedge clk); cyc++; end
      n_cmp++; if (!halted || pc !== 4'd4) begin n_fail++; $display("FAIL busy_end: got halted=%b pc=%0d expected 1/4", halted, pc); end
   endtask

   task automatic test_brz(input logic [3:0] v);
      int cyc;
      logic [11:0] e;
      logic [3:0]  exp_pc;
`ifdef CTRL_BRANCH_EN
      exp_pc = (v == 4'h0) ? 4'd6 : 4'd2;
`else
      exp_pc = 4'd2;
`endif
      fill_rom(8'hD0);
      rom[0] = {4'h0, v}; rom[1] = 8'hE6;
      exp_q.push_back(wr(2'd0, 2'd0, 2'd0, v, 1'b1, 1'b0));
      pulse_start();
      cyc = 1;
      while (!halted && cyc < 40) begin
         @(negedge clk); cyc++;
         if (write_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL brz_sb: unexpected write %h", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin n_fail++; $display("FAIL brz_sb: got %h expected %h", obs, e); end
            end
         end
      end
      n_cmp++; if (!halted || pc !== exp_pc) begin n_fail++; $display("FAIL brz_pc r0=%0d: got halted=%b pc=%0d expected 1/%0d", v, halted, pc, exp_pc); end
      n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL brz_left: got %0d expected 0", exp_q.size()); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) rf[i] = 4'h0;
      fill_rom(8'hD0);
      test_reset();
      test_push();
      test_alu();
      test_nop_wrap();
      test_reset_mid();
      test_start_busy();
      test_brz(4'h0);
      test_brz(4'h3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
